grant_lock_arbiter: RTL and testbench

GRANT_LOCK_ARBITER -- requirements
Module: grant_lock_arbiter

---
 rtl/grant_lock_arbiter_pkg.sv | 37 +++
 rtl/grant_beat_counter.sv | 64 ++++++
 rtl/grant_lock_arbiter.sv | 125 ++++++++++++
 tb/tb_grant_lock_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grant_lock_arbiter_pkg.sv
// Shared definitions for the two-input grant arbiter: field widths, builtin
// grant type codes, the default burst length and the multi-beat classifier.
package grant_lock_arbiter_pkg;

    localparam int unsigned SRC_W         = 2;
    localparam int unsigned DST_W         = 2;
    localparam int unsigned ADDR_BEAT_W   = 3;
    localparam int unsigned CXID_W        = 1;
    localparam int unsigned MXID_W        = 2;
    localparam int unsigned GTYPE_W       = 4;
    localparam int unsigned DATA_W        = 64;
    localparam int unsigned NB_MASK_W     = 16;
    localparam int unsigned DEFAULT_BEATS = 8;

    localparam logic [GTYPE_W-1:0] VOLUNTARY_ACK       = GTYPE_W'(0);
    localparam logic [GTYPE_W-1:0] PREFETCH_ACK        = GTYPE_W'(1);
    localparam logic [GTYPE_W-1:0] PUT_ACK             = GTYPE_W'(2);
    localparam logic [GTYPE_W-1:0] GET_DATA_BEAT_ACK   = GTYPE_W'(3);
    localparam logic [GTYPE_W-1:0] GET_DATA_BLOCK_ACK  = GTYPE_W'(4);

    typedef struct packed {
        logic [SRC_W-1:0]       header_src;
        logic [DST_W-1:0]       header_dst;
        logic [ADDR_BEAT_W-1:0] addr_beat;
        logic [CXID_W-1:0]      client_xact_id;
        logic [MXID_W-1:0]      manager_xact_id;
        logic                   is_builtin_type;
        logic [GTYPE_W-1:0]     g_type;
        logic [DATA_W-1:0]      data;
    } grant_t;

    // Builtin grants carry a block only for GetDataBlockAck; others use the mask.
    function automatic logic is_multi_beat(input grant_t g, input logic [NB_MASK_W-1:0] nb_mask);
        return g.is_builtin_type ? (g.g_type == GET_DATA_BLOCK_ACK) : nb_mask[g.g_type];
    endfunction

endpackage

// File: rtl/grant_beat_counter.sv
// Lock and beat-count state: holds the output on one requester for the
// duration of a multi-beat grant, counting beats by handshake only.
module grant_beat_counter #(
    parameter int unsigned BEATS = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_fire,
    input  logic i_is_multi,
    input  logic i_chosen,
    output logic o_locked,
    output logic o_lock_idx,
    output logic o_last_c
);

    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
    localparam bit MULTI_EN = (BEATS > 1);

    logic             r_locked;
    logic             r_lock_idx;
    logic [CNT_W-1:0] r_beat_cnt;
    logic             w_locked_nxt;
    logic             w_lock_idx_nxt;
    logic [CNT_W-1:0] w_beat_cnt_nxt;

    // Next-state: open a lock on the first beat of a block, close it on the last.
    always_comb begin
        w_locked_nxt   = r_locked;
        w_lock_idx_nxt = r_lock_idx;
        w_beat_cnt_nxt = r_beat_cnt;
        if (i_fire) begin
            if (r_locked) begin
                if (r_beat_cnt == LAST_CNT) begin
                    w_locked_nxt   = 1'b0;
                    w_beat_cnt_nxt = '0;
                end else begin
                    w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                end
            end else if (i_is_multi && MULTI_EN) begin
                w_locked_nxt   = 1'b1;
                w_lock_idx_nxt = i_chosen;
                w_beat_cnt_nxt = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked   <= 1'b0;
            r_lock_idx <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_locked   <= w_locked_nxt;
            r_lock_idx <= w_lock_idx_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    assign o_locked   = r_locked;
    assign o_lock_idx = r_lock_idx;
    assign o_last_c   = r_locked && (r_beat_cnt == LAST_CNT);

endmodule

// File: rtl/grant_lock_arbiter.sv
// Two-input round-robin grant arbiter that stays on one requester for the
// whole of a multi-beat grant; selection and data muxing live here.
module grant_lock_arbiter
    import grant_lock_arbiter_pkg::*;
#(
    parameter int unsigned            BEATS        = DEFAULT_BEATS,
    parameter logic [NB_MASK_W-1:0]   NB_DATA_MASK = 16'h0000
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   io_in_0_valid,
    output logic                   io_in_0_ready,
    input  logic [SRC_W-1:0]       io_in_0_bits_header_src,
    input  logic [DST_W-1:0]       io_in_0_bits_header_dst,
    input  logic [ADDR_BEAT_W-1:0] io_in_0_bits_payload_addr_beat,
    input  logic [CXID_W-1:0]      io_in_0_bits_payload_client_xact_id,
    input  logic [MXID_W-1:0]      io_in_0_bits_payload_manager_xact_id,
    input  logic                   io_in_0_bits_payload_is_builtin_type,
    input  logic [GTYPE_W-1:0]     io_in_0_bits_payload_g_type,
    input  logic [DATA_W-1:0]      io_in_0_bits_payload_data,

    input  logic                   io_in_1_valid,
    output logic                   io_in_1_ready,
    input  logic [SRC_W-1:0]       io_in_1_bits_header_src,
    input  logic [DST_W-1:0]       io_in_1_bits_header_dst,
    input  logic [ADDR_BEAT_W-1:0] io_in_1_bits_payload_addr_beat,
    input  logic [CXID_W-1:0]      io_in_1_bits_payload_client_xact_id,
    input  logic [MXID_W-1:0]      io_in_1_bits_payload_manager_xact_id,
    input  logic                   io_in_1_bits_payload_is_builtin_type,
    input  logic [GTYPE_W-1:0]     io_in_1_bits_payload_g_type,
    input  logic [DATA_W-1:0]      io_in_1_bits_payload_data,

    output logic                   io_out_valid,
    input  logic                   io_out_ready,
    output logic [SRC_W-1:0]       io_out_bits_header_src,
    output logic [DST_W-1:0]       io_out_bits_header_dst,
    output logic [ADDR_BEAT_W-1:0] io_out_bits_payload_addr_beat,
    output logic [CXID_W-1:0]      io_out_bits_payload_client_xact_id,
    output logic [MXID_W-1:0]      io_out_bits_payload_manager_xact_id,
    output logic                   io_out_bits_payload_is_builtin_type,
    output logic [GTYPE_W-1:0]     io_out_bits_payload_g_type,
    output logic [DATA_W-1:0]      io_out_bits_payload_data,

    output logic                   io_chosen,
    output logic                   io_locked
);

    localparam bit MULTI_EN = (BEATS > 1);

    grant_t w_in0;
    grant_t w_in1;
    grant_t w_out;
    logic   r_rr_ptr;
    logic   w_chosen;
    logic   w_out_valid;
    logic   w_fire;
    logic   w_is_multi;
    logic   w_msg_done;
    logic   w_locked;
    logic   w_lock_idx;
    logic   w_last;

    assign w_in0 = {io_in_0_bits_header_src, io_in_0_bits_header_dst,
                    io_in_0_bits_payload_addr_beat, io_in_0_bits_payload_client_xact_id,
                    io_in_0_bits_payload_manager_xact_id, io_in_0_bits_payload_is_builtin_type,
                    io_in_0_bits_payload_g_type, io_in_0_bits_payload_data};
    assign w_in1 = {io_in_1_bits_header_src, io_in_1_bits_header_dst,
                    io_in_1_bits_payload_addr_beat, io_in_1_bits_payload_client_xact_id,
                    io_in_1_bits_payload_manager_xact_id, io_in_1_bits_payload_is_builtin_type,
                    io_in_1_bits_payload_g_type, io_in_1_bits_payload_data};

    // A lone valid requester wins outright; ties and idle cycles follow rr_ptr.
    always_comb begin
        w_chosen = r_rr_ptr;
        if (w_locked) begin
            w_chosen = w_lock_idx;
        end else if (io_in_0_valid ^ io_in_1_valid) begin
            w_chosen = io_in_1_valid;
        end
    end

    assign w_out       = w_chosen ? w_in1 : w_in0;
    assign w_out_valid = w_chosen ? io_in_1_valid : io_in_0_valid;
    assign w_fire      = w_out_valid && io_out_ready;
    assign w_is_multi  = is_multi_beat(w_out, NB_DATA_MASK);
    assign w_msg_done  = w_fire && (w_locked ? w_last : !(w_is_multi && MULTI_EN));

    grant_beat_counter #(
        .BEATS (BEATS)
    ) u_beat_counter (
        .clk        (clk),
        .rst_n      (reset),
        .i_fire     (w_fire),
        .i_is_multi (w_is_multi),
        .i_chosen   (w_chosen),
        .o_locked   (w_locked),
        .o_lock_idx (w_lock_idx),
        .o_last_c   (w_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= 1'b0;
        end else if (w_msg_done) begin
            r_rr_ptr <= ~w_chosen;
        end
    end

    assign io_in_0_ready = io_out_ready && !w_chosen && (!w_locked || !w_lock_idx);
    assign io_in_1_ready = io_out_ready &&  w_chosen && (!w_locked ||  w_lock_idx);
    assign io_out_valid  = w_out_valid;
    assign io_chosen     = w_chosen;
    assign io_locked     = w_locked;

    assign io_out_bits_header_src              = w_out.header_src;
    assign io_out_bits_header_dst              = w_out.header_dst;
    assign io_out_bits_payload_addr_beat       = w_out.addr_beat;
    assign io_out_bits_payload_client_xact_id  = w_out.client_xact_id;
    assign io_out_bits_payload_manager_xact_id = w_out.manager_xact_id;
    assign io_out_bits_payload_is_builtin_type = w_out.is_builtin_type;
    assign io_out_bits_payload_g_type          = w_out.g_type;
    assign io_out_bits_payload_data            = w_out.data;

endmodule

// File: tb/tb_grant_lock_arbiter.sv
// Scoreboard bench for grant_lock_arbiter: sources replay queued beats,
// expected grants are queued in the order they must appear at the output.
module tb_grant_lock_arbiter;
    import grant_lock_arbiter_pkg::*;

    typedef struct {
        logic   idx;
        grant_t bits;
        logic   locked;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset = 1'b0;
    logic   io_in_0_valid = 1'b0;
    logic   io_in_1_valid = 1'b0;
    logic   io_out_ready = 1'b0;
    grant_t in0 = '0;
    grant_t in1 = '0;
    logic   io_in_0_ready, io_in_1_ready, io_out_valid, io_chosen, io_locked;
    logic [SRC_W-1:0]       o_src;
    logic [DST_W-1:0]       o_dst;
    logic [ADDR_BEAT_W-1:0] o_ab;
    logic [CXID_W-1:0]      o_cx;
    logic [MXID_W-1:0]      o_mx;
    logic                   o_bi;
    logic [GTYPE_W-1:0]     o_gt;
    logic [DATA_W-1:0]      o_data;
    grant_t out_bits;

    grant_t src_q0[$];
    grant_t src_q1[$];
    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    logic   last_fire;
    logic   last_chosen;

    always #5 clk = ~clk;

    grant_lock_arbiter #(
        .BEATS        (8),
        .NB_DATA_MASK (16'h0002)
    ) dut (
        .clk                                  (clk),
        .reset                                (reset),
        .io_in_0_valid                        (io_in_0_valid),
        .io_in_0_ready                        (io_in_0_ready),
        .io_in_0_bits_header_src              (in0.header_src),
        .io_in_0_bits_header_dst              (in0.header_dst),
        .io_in_0_bits_payload_addr_beat       (in0.addr_beat),
        .io_in_0_bits_payload_client_xact_id  (in0.client_xact_id),
        .io_in_0_bits_payload_manager_xact_id (in0.manager_xact_id),
        .io_in_0_bits_payload_is_builtin_type (in0.is_builtin_type),
        .io_in_0_bits_payload_g_type          (in0.g_type),
        .io_in_0_bits_payload_data            (in0.data),
        .io_in_1_valid                        (io_in_1_valid),
        .io_in_1_ready                        (io_in_1_ready),
        .io_in_1_bits_header_src              (in1.header_src),
        .io_in_1_bits_header_dst              (in1.header_dst),
        .io_in_1_bits_payload_addr_beat       (in1.addr_beat),
        .io_in_1_bits_payload_client_xact_id  (in1.client_xact_id),
        .io_in_1_bits_payload_manager_xact_id (in1.manager_xact_id),
        .io_in_1_bits_payload_is_builtin_type (in1.is_builtin_type),
        .io_in_1_bits_payload_g_type          (in1.g_type),
        .io_in_1_bits_payload_data            (in1.data),
        .io_out_valid                         (io_out_valid),
        .io_out_ready                         (io_out_ready),
        .io_out_bits_header_src               (o_src),
        .io_out_bits_header_dst               (o_dst),
        .io_out_bits_payload_addr_beat        (o_ab),
        .io_out_bits_payload_client_xact_id   (o_cx),
        .io_out_bits_payload_manager_xact_id  (o_mx),
        .io_out_bits_payload_is_builtin_type  (o_bi),
        .io_out_bits_payload_g_type           (o_gt),
        .io_out_bits_payload_data             (o_data),
        .io_chosen                            (io_chosen),
        .io_locked                            (io_locked)
    );

    assign out_bits = {o_src, o_dst, o_ab, o_cx, o_mx, o_bi, o_gt, o_data};

    function automatic grant_t mk(input int k, input logic bi, input logic [3:0] gt,
                                  input int id, input int b);
        grant_t g;
        g.header_src      = 2'(k);
        g.header_dst      = 2'(id);
        g.addr_beat       = 3'(b);
        g.client_xact_id  = 1'(id);
        g.manager_xact_id = 2'(b);
        g.is_builtin_type = bi;
        g.g_type          = gt;
        g.data            = {8'(k), 8'(id), 16'(b), 32'hDEAD_0000 + 32'(id * 16 + b)};
        return g;
    endfunction

    task automatic send(input int k, input logic bi, input logic [3:0] gt, input int n, input int id);
        for (int b = 0; b < n; b++) begin
            if (k == 0) src_q0.push_back(mk(k, bi, gt, id, b));
            else        src_q1.push_back(mk(k, bi, gt, id, b));
        end
    endtask

    task automatic expect_msg(input int k, input logic bi, input logic [3:0] gt, input int n, input int id);
        exp_t e;
        for (int b = 0; b < n; b++) begin
            e.idx    = 1'(k);
            e.bits   = mk(k, bi, gt, id, b);
            e.locked = (b > 0);
            exp_q.push_back(e);
        end
    endtask

    // One clock: drive queue heads, sample after settling, score any accepted beat.
    task automatic cycle(input logic rdy);
        exp_t e;
        @(negedge clk);
        io_in_0_valid = (src_q0.size() > 0);
        in0           = (src_q0.size() > 0) ? src_q0[0] : '0;
        io_in_1_valid = (src_q1.size() > 0);
        in1           = (src_q1.size() > 0) ? src_q1[0] : '0;
        io_out_ready  = rdy;
        #1;
        last_fire   = io_out_valid && io_out_ready;
        last_chosen = io_chosen;
        if (last_fire) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat chosen=%0d data=%h", io_chosen, o_data);
            end else begin
                e = exp_q.pop_front();
                if (io_chosen !== e.idx || out_bits !== e.bits || io_locked !== e.locked) begin
                    errors++;
                    $display("FAIL beat got chosen=%0d locked=%0d bits=%h want chosen=%0d locked=%0d bits=%h",
                             io_chosen, io_locked, out_bits, e.idx, e.locked, e.bits);
                end
            end
            if (io_in_0_ready && src_q0.size() > 0) src_q0.delete(0);
            if (io_in_1_ready && src_q1.size() > 0) src_q1.delete(0);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            cycle(1'b1);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d want 0", exp_q.size());
            exp_q.delete();
            src_q0.delete();
            src_q1.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (io_locked !== 1'b0 || io_chosen !== 1'b0 || io_out_valid !== 1'b0 ||
            dut.u_beat_counter.r_beat_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_state locked=%0d chosen=%0d valid=%0d cnt=%0d want 0 0 0 0",
                     io_locked, io_chosen, io_out_valid, dut.u_beat_counter.r_beat_cnt);
        end
        reset = 1'b1;
        cycle(1'b1);
        checks++;
        if (io_chosen !== 1'b0 || io_locked !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset chosen=%0d locked=%0d want 0 0", io_chosen, io_locked);
        end
    endtask

    task automatic test_lock();
        send(0, 1'b1, GET_DATA_BLOCK_ACK, 8, 1);
        send(1, 1'b1, PUT_ACK, 1, 2);
        expect_msg(0, 1'b1, GET_DATA_BLOCK_ACK, 8, 1);
        expect_msg(1, 1'b1, PUT_ACK, 1, 2);
        drain(40);
    endtask

    task automatic test_alternate();
        send(0, 1'b1, PUT_ACK, 1, 10);
        send(0, 1'b1, PUT_ACK, 1, 11);
        send(1, 1'b1, PUT_ACK, 1, 12);
        send(1, 1'b1, PUT_ACK, 1, 13);
        expect_msg(0, 1'b1, PUT_ACK, 1, 10);
        expect_msg(1, 1'b1, PUT_ACK, 1, 12);
        expect_msg(0, 1'b1, PUT_ACK, 1, 11);
        expect_msg(1, 1'b1, PUT_ACK, 1, 13);
        drain(20);
    endtask

    task automatic test_stall();
        send(0, 1'b1, GET_DATA_BLOCK_ACK, 8, 20);
        expect_msg(0, 1'b1, GET_DATA_BLOCK_ACK, 8, 20);
        repeat (3) cycle(1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0);
            checks++;
            if (io_out_valid !== 1'b1 || io_locked !== 1'b1 || io_in_0_ready !== 1'b0 ||
                dut.u_beat_counter.r_beat_cnt !== 3'd3) begin
                errors++;
                $display("FAIL stall_hold valid=%0d locked=%0d ready0=%0d cnt=%0d want 1 1 0 3",
                         io_out_valid, io_locked, io_in_0_ready, dut.u_beat_counter.r_beat_cnt);
            end
        end
        repeat (5) cycle(1'b1);
        cycle(1'b1);
        checks++;
        if (exp_q.size() != 0 || io_locked !== 1'b0) begin
            errors++;
            $display("FAIL stall_complete pending=%0d locked=%0d want 0 0", exp_q.size(), io_locked);
        end
        drain(5);
    endtask

    task automatic test_reset_mid();
        send(0, 1'b1, GET_DATA_BLOCK_ACK, 8, 30);
        expect_msg(0, 1'b1, GET_DATA_BLOCK_ACK, 8, 30);
        repeat (4) cycle(1'b1);
        checks++;
        if (exp_q.size() != 4 || io_locked !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset pending=%0d locked=%0d want 4 1", exp_q.size(), io_locked);
        end
        @(negedge clk);
        reset = 1'b0;
        io_in_0_valid = 1'b0;
        io_in_1_valid = 1'b0;
        #1;
        checks++;
        if (io_locked !== 1'b0 || dut.u_beat_counter.r_beat_cnt !== 3'd0) begin
            errors++;
            $display("FAIL async_reset locked=%0d cnt=%0d want 0 0",
                     io_locked, dut.u_beat_counter.r_beat_cnt);
        end
        exp_q.delete();
        src_q0.delete();
        src_q1.delete();
        @(negedge clk);
        reset = 1'b1;
        send(0, 1'b1, PUT_ACK, 1, 31);
        send(1, 1'b1, PUT_ACK, 1, 32);
        expect_msg(0, 1'b1, PUT_ACK, 1, 31);
        expect_msg(1, 1'b1, PUT_ACK, 1, 32);
        drain(10);
        send(1, 1'b1, PUT_ACK, 1, 33);
        expect_msg(1, 1'b1, PUT_ACK, 1, 33);
        drain(5);
    endtask

    task automatic test_nb_mask();
        send(0, 1'b0, 4'd1, 8, 40);
        send(0, 1'b0, 4'd0, 1, 41);
        send(0, 1'b0, 4'd0, 1, 42);
        expect_msg(0, 1'b0, 4'd1, 8, 40);
        expect_msg(0, 1'b0, 4'd0, 1, 41);
        expect_msg(0, 1'b0, 4'd0, 1, 42);
        drain(30);
    endtask

    task automatic test_no_bubble();
        send(1, 1'b1, PUT_ACK, 1, 50);
        expect_msg(1, 1'b1, PUT_ACK, 1, 50);
        drain(5);
        send(1, 1'b1, PUT_ACK, 1, 51);
        expect_msg(1, 1'b1, PUT_ACK, 1, 51);
        cycle(1'b1);
        checks++;
        if (last_fire !== 1'b1 || last_chosen !== 1'b1) begin
            errors++;
            $display("FAIL no_bubble fire=%0d chosen=%0d want 1 1", last_fire, last_chosen);
        end
        drain(5);
    endtask

    initial begin
        test_reset();
        test_lock();
        test_alternate();
        test_stall();
        test_reset_mid();
        test_nb_mask();
        test_no_bubble();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout sim_time=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
